// File: rtl/minute_pkg.sv
// minute_pkg: shared widths, latency bounds and FSM encoding for the instruction memory.
package minute_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int INSTR_SIZE = 32;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;
  typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: word array with one synchronous read port and one write port, read-before-write.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] q,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (re) q <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/imem_lat.sv
// imem_lat: instruction memory with LATENCY wait-states and a one-cycle ready pulse.
// Optional IMEM_ERR_EN adds the misaligned/out-of-range error flag and drops misaligned writes.
module imem_lat
  import minute_pkg::*;
#(
  parameter int ADDR_W = ADDR_SIZE,
  parameter int DATA_W = INSTR_SIZE,
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              enable,
  output logic [DATA_W-1:0] data,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX || DEPTH < 4 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("imem_lat: illegal LATENCY or DEPTH");
  end
  state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] q, hold;
  logic accept, fin, we, unused_bits;
  assign accept = state == IDLE && enable && !reset;
  assign fin = state == WAIT && cnt == CW'(1);
  assign unused_bits = ^{addr, wr_addr};
  // The RAM register holds the word from accept; hold keeps it visible after ready drops.
  assign data = ready ? q : hold;
  imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(IW)) u_ram (
    .clk(clk),
    .re(accept),
    .raddr(addr[IW+1:2]),
    .q(q),
    .we(we),
    .waddr(wr_addr[IW+1:2]),
    .wdata(wr_data)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ready <= 1'b0;
      hold <= '0;
    end else begin
      ready <= fin || (accept && LATENCY == 1);
      if (ready) hold <= q;
      if (accept && LATENCY > 1) begin
        state <= WAIT;
        cnt <= CW'(LATENCY - 1);
      end else if (state == WAIT) begin
        state <= fin ? IDLE : WAIT;
        cnt <= cnt - CW'(1);
      end
    end
`ifdef IMEM_ERR_EN
  localparam logic [ADDR_W-1:0] IDX_MASK = ((ADDR_W'(1) << (IW + 2)) - ADDR_W'(1)) & ~ADDR_W'(3);
  logic bad, err_q;
  assign bad = |(addr & ~IDX_MASK);
  assign we = wr_en && !reset && wr_addr[1:0] == 2'b00;
  always_ff @(posedge clk)
    if (reset) begin
      err <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err <= fin ? err_q : accept && LATENCY == 1 && bad;
      if (accept) err_q <= bad;
    end
`else
  assign we = wr_en && !reset;
  assign err = 1'b0;
`endif
endmodule
